// File: rtl/timer_arbiter_pkg.sv
// Shared types and default widths for the round-robin timer arbiter.
package timer_arbiter_pkg;

  typedef enum logic {IDLE, RUN} arbState_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bundle: request levels, packed durations, abort, and the grant/done returns.
interface timer_arbiter_if
  import timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] duration;
  logic                     abort;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [NUM_REQ-1:0]       timerDone;

  modport master (
    output req, duration, abort,
    input  grant, busy, timerDone
  );

  modport slave (
    input  req, duration, abort,
    output grant, busy, timerDone
  );

endinterface

// File: rtl/timer_arbiter_interval_timer.sv
// Shared interval counter: latches a duration on load and flags the final cycle of the interval.
module interval_timer
  import timer_arbiter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             clear,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] durQ_q;

  // Zero-length requests still get one cycle; count saturates at durQ so it cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      durQ_q  <= '0;
    end else if (load) begin
      count_q <= CNT_W'(1);
      durQ_q  <= (loadVal == '0) ? CNT_W'(1) : loadVal;
    end else if (clear) begin
      count_q <= '0;
      durQ_q  <= '0;
    end else if ((count_q != '0) && (count_q != durQ_q)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign done = (count_q != '0) && (count_q == durQ_q);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner selection for one shared interval timer, with abort/withdraw release.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  timer_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arbState_t          state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   ptr_q;

  logic [CNT_W-1:0]   dur_arr [NUM_REQ];
  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   cand;
  int                 idx;
  logic               owner_req;
  logic               done;
  logic               exit_run;
  logic               load;
  logic               clear;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      dur_arr[i] = bus.duration[i*CNT_W +: CNT_W];
    end
  end

  // Search starts one past the last owner so every requester gets its turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign owner_req = |(bus.req & grant_q);
  assign exit_run  = done | bus.abort | ~owner_req;
  assign load      = (state_q == IDLE) && sel_found;
  assign clear     = (state_q == RUN) && exit_run;

  interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .loadVal (dur_arr[sel_idx]),
    .clear   (clear),
    .done    (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_q <= RUN;
            grant_q <= NUM_REQ'(1) << sel_idx;
            ptr_q   <= sel_idx;
          end
        end
        RUN: begin
          if (exit_run) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Abort beats done in the same cycle; a withdrawn requester never sees a pulse.
  assign bus.timerDone = (state_q == RUN) ?
                         (grant_q & bus.req & {NUM_REQ{done & ~bus.abort}}) : '0;
  assign bus.grant     = grant_q;
  assign bus.busy      = |grant_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: expected per-cycle grant/done pushed at stimulus time.
module tb_timer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] d;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  timer_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  timer_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [NUM_REQ-1:0] g, input logic [NUM_REQ-1:0] d, input int n);
    exp_t e;
    e.g = g;
    e.d = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic [CNT_W-1:0] dur);
    bus.req[idx] = 1'b1;
    bus.duration[idx*CNT_W +: CNT_W] = dur;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Normal completion: requester drops req the cycle after its timerDone.
  task automatic run_interval(input int idx, input logic [CNT_W-1:0] dur);
    int d;
    logic [NUM_REQ-1:0] g;
    d = (dur == '0) ? 1 : int'(dur);
    g = NUM_REQ'(1) << idx;
    set_req(idx, dur);
    push_n('0, '0, 1);
    push_n(g, '0, d - 1);
    push_n(g, g, 1);
    push_n('0, '0, 1);
    cyc(d + 1);
    bus.req[idx] = 1'b0;
    cyc(1);
    wait_drain();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("grant", 32'(bus.grant), 32'(e.g));
      chk("timerDone", 32'(bus.timerDone), 32'(e.d));
      chk("busy", 32'(bus.busy), 32'(|e.g));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] g;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req      = '0;
    bus.duration = '0;
    bus.abort    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.timerDone), 32'd0);
    reset = 1'b0;

    // single request, duration 3
    run_interval(0, 8'd3);

    // round robin from fresh reset: 0,1,2,3,0
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'd2);
    push_n('0, '0, 1);
    for (int k = 0; k < 5; k++) begin
      g = NUM_REQ'(1) << (k % NUM_REQ);
      push_n(g, '0, 1);
      push_n(g, g, 1);
      push_n('0, '0, 1);
    end
    cyc(15);
    bus.req = '0;
    cyc(1);
    wait_drain();

    // zero and maximum durations
    run_interval(2, 8'd0);
    run_interval(3, 8'd255);

    // abort mid-interval
    set_req(0, 8'd5);
    push_n('0, '0, 1);
    push_n(4'b0001, '0, 2);
    push_n('0, '0, 1);
    cyc(2);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    bus.req   = '0;
    cyc(1);
    wait_drain();

    // withdrawal mid-interval
    set_req(1, 8'd5);
    push_n('0, '0, 1);
    push_n(4'b0010, '0, 2);
    push_n('0, '0, 1);
    cyc(2);
    bus.req = '0;
    cyc(2);
    wait_drain();

    // abort coincident with done
    set_req(2, 8'd3);
    push_n('0, '0, 1);
    push_n(4'b0100, '0, 3);
    push_n('0, '0, 1);
    cyc(3);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    bus.req   = '0;
    cyc(1);
    wait_drain();

    // duration change and new request during RUN
    set_req(0, 8'd4);
    push_n('0, '0, 1);
    push_n(4'b0001, '0, 3);
    push_n(4'b0001, 4'b0001, 1);
    push_n('0, '0, 1);
    push_n(4'b0100, '0, 1);
    push_n(4'b0100, 4'b0100, 1);
    push_n('0, '0, 1);
    cyc(2);
    bus.duration[0 +: CNT_W] = 8'd1;
    set_req(2, 8'd2);
    cyc(3);
    bus.req[0] = 1'b0;
    cyc(3);
    bus.req[2] = 1'b0;
    cyc(1);
    wait_drain();

    // asynchronous reset during the done cycle
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'd2);
    push_n('0, '0, 1);
    push_n(4'b1000, '0, 1);
    cyc(2);
    #1;
    chk("pre_rst_done", 32'(bus.timerDone), 32'h8);
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(bus.grant), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_done", 32'(bus.timerDone), 32'd0);
    cyc(1);
    reset = 1'b0;
    push_n('0, '0, 1);
    push_n(4'b0001, '0, 1);
    push_n(4'b0001, 4'b0001, 1);
    push_n('0, '0, 1);
    cyc(3);
    bus.req = '0;
    cyc(1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
